fifo_drain_reader: RTL and testbench
====================================

Name: fifo_drain_reader

Overview:
- Read-side engine for the project `fifo`: it consumes words from the FIFO's show-ahead output (`output_data`/`empty`/`read`).
- Presents each word downstream on a valid/ready stream with a one-entry output register.
- Paces pops so the FIFO's `empty` flag is only sampled once it has settled after each read.
- Sits between `fifo` and any downstream consumer; it replaces bench-driven read pulses.

Parameters:
- DATA_WIDTH, 32, width of FIFO data and output stream.
- SETTLE_CYCLES, 1, cycles (>=1) after each read pulse during which `fifo_empty`/`fifo_output_data` are ignored.
- COUNT_WIDTH, 16, width of the popped-word counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enable  in  1  1 = may start new pops; 0 = no new pops, an in-flight pop completes.
- fifo_empty  in  1  FIFO empty flag.
- fifo_output_data  in  DATA_WIDTH  FIFO show-ahead head word, valid while fifo_empty=0 and settled.
- fifo_read  out  1  registered one-cycle pop pulse to FIFO.
- out_data  out  DATA_WIDTH  downstream data.
- out_valid  out  1  downstream valid.
- out_ready  in  1  downstream ready.
- pop_count  out  COUNT_WIDTH  number of words popped, wraps modulo 2^COUNT_WIDTH.
- idle  out  1  combinational: state==IDLE && out_valid==0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, fifo_read=0, out_valid=0, out_data=0, pop_count=0, settle counter=0. Outputs clear immediately, not at the next edge.
- FSM states: IDLE, POP, SETTLE.
- IDLE -> POP when enable=1 && fifo_empty=0 && out_valid=0 (sampled at the edge). Otherwise stay in IDLE.
- POP lasts exactly one cycle, with fifo_read=1 only in this state.
  - At the POP-exit edge: out_data <= fifo_output_data, out_valid <= 1, pop_count <= pop_count+1.
  - Next state is SETTLE with the settle counter loaded to SETTLE_CYCLES.
- SETTLE: fifo_read=0, and fifo_empty/fifo_output_data are ignored. The counter decrements each cycle; leave to IDLE when it reaches 0. Duration is SETTLE_CYCLES cycles.
- Downstream handshake: a transfer occurs on an edge with out_valid=1 && out_ready=1, after which out_valid <= 0.
  - out_data is stable while out_valid=1 && out_ready=0.
  - out_ready is ignored when out_valid=0.
- No overwrite: POP is never entered while out_valid=1, so fifo_read is never asserted with an untaken word in the output register.
- Throughput: at most one word per (2+SETTLE_CYCLES) cycles, plus any downstream stall. With SETTLE_CYCLES=1 and out_ready=1 that is one word per 3 cycles at best. Minimum spacing between fifo_read pulses is 2+SETTLE_CYCLES cycles.
- enable falling during POP or SETTLE: the sequence completes normally and the word is delivered; no further pops follow.
- Empty: fifo_empty=1 in IDLE leaves fifo_read at 0 indefinitely; there is no timeout.
- Full: the block never drives FIFO write/full and is unaffected by them.
- pop_count wraps from all-ones to 0 without a flag.
- Reset mid-POP: fifo_read drops at once. The pop is not counted and out_valid=0. Whether the FIFO registered that pop is the FIFO's concern.
- Data width: out_data is a straight copy of fifo_output_data; no arithmetic is applied.

Test Plan:
- Single word: write 32'd10 into the FIFO, wait for empty=0, out_ready=1, enable=1.
  - One fifo_read pulse occurs.
  - Next cycle out_data=10, out_valid=1, pop_count=1.
  - After settle, idle=1, and the FIFO reports empty=1 with output_data=0.
- Burst: preload 10, 20, 30 with out_ready=1.
  - Exactly three fifo_read pulses, spaced exactly 3 cycles apart (SETTLE_CYCLES=1).
  - out_data sequence is 10, 20, 30, ending with pop_count=3.
  - No read is issued while empty=1.
- Backpressure: preload 10 and 20, out_ready=0 for 8 cycles.
  - out_data=10 and out_valid=1 are held.
  - Only one fifo_read is issued during the stall.
  - Raising out_ready gives 10 then 20, each transferred once.
- Enable: preload 5 words, drop enable at the cycle fifo_read=1 for the second word.
  - Second word is delivered; pop_count=2.
  - No third read occurs until enable=1 again, after which words 3-5 follow.
- Reset mid-operation: assert reset=0 asynchronously between edges while fifo_read=1.
  - fifo_read, out_valid and pop_count all read 0 before the next edge.
  - After release the block returns to IDLE and resumes on the remaining FIFO contents.
- Wrap: COUNT_WIDTH=4, stream 17 words.
  - pop_count reads 0 after the 16th word and 1 after the 17th.
  - Data order is preserved throughout.

Source files
------------

// File: rtl/fifo_drain_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_reader
// Purpose  : Pops words from a show-ahead FIFO and presents them on a
//            valid/ready stream, pacing reads so the FIFO flags can settle.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_drain_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_output_data,
    output logic                   fifo_read,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] pop_count,
    output logic                   idle
);

    localparam int                   SETTLE_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SETTLE_W-1:0]     settle_q, settle_d;
    logic                    fifo_read_q, fifo_read_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [COUNT_WIDTH-1:0]  pop_count_q, pop_count_d;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        pop_count_d = pop_count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Only pop into an empty output register, so nothing is overwritten.
                if (enable && !fifo_empty && !out_valid_q) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d     = ST_SETTLE;
                settle_d    = SETTLE_LOAD;
                out_data_d  = fifo_output_data;
                out_valid_d = 1'b1;
                pop_count_d = pop_count_q + COUNT_WIDTH'(1);
            end
            ST_SETTLE: begin
                if (settle_q <= SETTLE_W'(1)) begin
                    settle_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                settle_d = '0;
            end
        endcase

        fifo_read_d = (state_d == ST_POP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            fifo_read_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pop_count_q <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            fifo_read_q <= fifo_read_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            pop_count_q <= pop_count_d;
        end
    end

    assign fifo_read = fifo_read_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign pop_count = pop_count_q;
    assign idle      = (state_q == ST_IDLE) && !out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_drain_reader
// Purpose  : Self-checking bench: FIFO model, cycle table, directed corner
//            sequences and randomized traffic against a stream scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_reader;

    localparam int DW      = 32;
    localparam int SC      = 1;
    localparam int CW      = 4;
    localparam int SPACING = 2 + SC;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_output_data = '0;
    logic          fifo_read, out_valid, idle;
    logic [DW-1:0] out_data;
    logic [CW-1:0] pop_count;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] sb[$];
    bit            mon_en = 1'b0;
    int            reads_seen = 0;
    int            xfer_cnt = 0;
    longint        cyc = 0;
    longint        last_read = -100;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] mon_exp;
    int            junk = 0;

    fifo_drain_reader #(
        .DATA_WIDTH    (DW),
        .SETTLE_CYCLES (SC),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .fifo_empty       (fifo_empty),
        .fifo_output_data (fifo_output_data),
        .fifo_read        (fifo_read),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .pop_count        (pop_count),
        .idle             (idle)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    // Show-ahead FIFO model; flags are garbage for SC cycles after a read.
    always @(posedge clk) begin
        if (fifo_read) begin
            chk("underflow", fq.size() != 0, fq.size(), 1);
            if (fq.size() != 0) void'(fq.pop_front());
            junk = SC;
        end
        if (junk > 0) begin
            fifo_empty       <= 1'($urandom_range(0, 1));
            fifo_output_data <= DW'($urandom);
            junk--;
        end else begin
            fifo_empty       <= (fq.size() == 0);
            fifo_output_data <= (fq.size() != 0) ? fq[0] : '0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("pop_count", pop_count == CW'(reads_seen), pop_count, CW'(reads_seen));
            if (prev_stall)
                chk("stall_hold", out_valid && out_data == prev_data, out_data, prev_data);
            if (fifo_read) begin
                chk("no_overwrite", !out_valid, out_valid, 0);
                chk("read_spacing", cyc - last_read >= SPACING, cyc - last_read, SPACING);
                last_read = cyc;
                reads_seen++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_xfer", 1'b0, out_data, 0);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("xfer_data", out_data == mon_exp, out_data, mon_exp);
                end
                xfer_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        fq.push_back(d);
        sb.push_back(d);
    endtask

    task automatic resync();
        reads_seen = 0;
        sb         = fq;
        last_read  = -100;
        prev_stall = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || !idle) && n < budget) begin
            tick();
            n++;
        end
        chk(nm, n < budget, n, budget);
    endtask

    typedef struct {
        bit            en;
        bit            rdy;
        bit            psh;
        logic [DW-1:0] pd;
        bit            e_read;
        bit            e_valid;
        logic [DW-1:0] e_data;
        int            e_cnt;
        bit            e_idle;
    } vec_t;

    function automatic vec_t mk(input bit en, input bit rdy, input bit psh, input int pd,
                                input bit er, input bit ev, input int ed, input int ec, input bit ei);
        vec_t v;
        v.en = en; v.rdy = rdy; v.psh = psh; v.pd = DW'(pd);
        v.e_read = er; v.e_valid = ev; v.e_data = DW'(ed); v.e_cnt = ec; v.e_idle = ei;
        return v;
    endfunction

    initial begin
        vec_t tbl[17];
        int   base, nr, x0, npush;

        tbl[0]  = mk(1, 1, 1, 10, 0, 0,  0, 0, 1);
        tbl[1]  = mk(1, 1, 0,  0, 0, 0,  0, 0, 1);
        tbl[2]  = mk(1, 1, 0,  0, 1, 0,  0, 0, 0);
        tbl[3]  = mk(1, 1, 0,  0, 0, 1, 10, 1, 0);
        tbl[4]  = mk(1, 1, 0,  0, 0, 0, 10, 1, 1);
        tbl[5]  = mk(1, 1, 1, 20, 0, 0, 10, 1, 1);
        tbl[6]  = mk(1, 1, 1, 30, 0, 0, 10, 1, 1);
        tbl[7]  = mk(1, 1, 1, 40, 1, 0, 10, 1, 0);
        tbl[8]  = mk(1, 1, 0,  0, 0, 1, 20, 2, 0);
        tbl[9]  = mk(1, 1, 0,  0, 0, 0, 20, 2, 1);
        tbl[10] = mk(1, 1, 0,  0, 1, 0, 20, 2, 0);
        tbl[11] = mk(1, 1, 0,  0, 0, 1, 30, 3, 0);
        tbl[12] = mk(1, 1, 0,  0, 0, 0, 30, 3, 1);
        tbl[13] = mk(1, 1, 0,  0, 1, 0, 30, 3, 0);
        tbl[14] = mk(1, 1, 0,  0, 0, 1, 40, 4, 0);
        tbl[15] = mk(1, 1, 0,  0, 0, 0, 40, 4, 1);
        tbl[16] = mk(1, 1, 0,  0, 0, 0, 40, 4, 1);

        // Asynchronous reset asserted before any clock edge.
        #1 reset = 1'b0;
        #2;
        chk("rst0_read",  fifo_read == 1'b0, fifo_read, 0);
        chk("rst0_valid", out_valid == 1'b0, out_valid, 0);
        chk("rst0_data",  out_data == '0, out_data, 0);
        chk("rst0_count", pop_count == '0, pop_count, 0);
        chk("rst0_idle",  idle == 1'b1, idle, 1);
        repeat (2) tick();
        reset  = 1'b1;
        mon_en = 1'b1;

        // Single word followed by a three-word burst, cycle by cycle.
        for (int i = 0; i < 17; i++) begin
            tick();
            enable    = tbl[i].en;
            out_ready = tbl[i].rdy;
            if (tbl[i].psh) push(tbl[i].pd);
            @(negedge clk);
            chk($sformatf("tbl%0d_read", i),  fifo_read == tbl[i].e_read, fifo_read, tbl[i].e_read);
            chk($sformatf("tbl%0d_valid", i), out_valid == tbl[i].e_valid, out_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_data", i),  out_data == tbl[i].e_data, out_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_count", i), pop_count == CW'(tbl[i].e_cnt), pop_count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_idle", i),  idle == tbl[i].e_idle, idle, tbl[i].e_idle);
        end

        // Backpressure: one word held, only one pop during the stall.
        tick();
        out_ready = 1'b0;
        push(50);
        push(60);
        base = reads_seen;
        repeat (10) tick();
        @(negedge clk);
        chk("bp_valid", out_valid == 1'b1, out_valid, 1);
        chk("bp_data",  out_data == 50, out_data, 50);
        chk("bp_reads", reads_seen - base == 1, reads_seen - base, 1);
        tick();
        out_ready = 1'b1;
        drain("bp_drain", 50);
        chk("bp_count", pop_count == CW'(6), pop_count, 6);

        // Enable dropped in the cycle of the second pop.
        tick();
        for (int i = 0; i < 5; i++) push(DW'(70 + i));
        base = reads_seen;
        nr   = 0;
        for (int i = 0; i < 60 && nr < 2; i++) begin
            tick();
            if (fifo_read) nr++;
        end
        enable = 1'b0;
        chk("en_second_read", nr == 2, nr, 2);
        repeat (15) tick();
        @(negedge clk);
        chk("en_count",  pop_count == CW'(8), pop_count, 8);
        chk("en_reads",  reads_seen - base == 2, reads_seen - base, 2);
        chk("en_paused", sb.size() == 3 && !out_valid, sb.size(), 3);
        tick();
        enable = 1'b1;
        drain("en_drain", 100);
        chk("en_count_end", pop_count == CW'(11), pop_count, 11);

        // Reset asserted between edges while a pop is in flight.
        tick();
        push(80);
        push(81);
        nr = 0;
        for (int i = 0; i < 20 && !fifo_read; i++) tick();
        chk("rst_found_pop", fifo_read == 1'b1, fifo_read, 1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("rst_read",  fifo_read == 1'b0, fifo_read, 0);
        chk("rst_valid", out_valid == 1'b0, out_valid, 0);
        chk("rst_count", pop_count == '0, pop_count, 0);
        chk("rst_idle",  idle == 1'b1, idle, 1);
        tick();
        tick();
        reset = 1'b1;
        resync();
        mon_en = 1'b1;
        drain("rst_drain", 50);
        chk("rst_resume_count", pop_count == CW'(2), pop_count, 2);

        // Counter wrap over 17 words from a fresh reset.
        tick();
        mon_en = 1'b0;
        reset  = 1'b0;
        tick();
        reset = 1'b1;
        resync();
        mon_en = 1'b1;
        x0 = xfer_cnt;
        for (int i = 0; i < 17; i++) push(DW'(32'h100 + i));
        nr = 0;
        while (xfer_cnt - x0 < 16 && nr < 200) begin
            @(negedge clk);
            nr++;
        end
        chk("wrap16_wait",  nr < 200, nr, 200);
        chk("wrap16_count", pop_count == '0, pop_count, 0);
        nr = 0;
        while (xfer_cnt - x0 < 17 && nr < 50) begin
            @(negedge clk);
            nr++;
        end
        chk("wrap17_wait",  nr < 50, nr, 50);
        chk("wrap17_count", pop_count == CW'(1), pop_count, 1);
        drain("wrap_drain", 50);

        // Randomized traffic, enable and backpressure.
        x0    = xfer_cnt;
        npush = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                push(DW'($urandom));
                npush++;
            end
        end
        tick();
        enable    = 1'b1;
        out_ready = 1'b1;
        drain("rand_drain", 3000);
        chk("rand_all_delivered", xfer_cnt - x0 == npush, xfer_cnt - x0, npush);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
